// File: rtl/fifo_write_arbiter_if.sv
// fifo_write_arbiter_if
// Bundles the producer handshake, the FIFO write port and the arbiter
// status lines into one interface.
//   master : arbiter side (drives req_ready, fifo_write_en, fifo_data_in,
//            grant_id, busy)
//   slave  : producers + FIFO side (drives req_valid, req_data, fifo_full,
//            fifo_almost_full)
interface fifo_write_arbiter_if #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 8
);
  localparam int IDW = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ*WIDTH-1:0] req_data;
  logic [NUM_REQ-1:0]       req_ready;
  logic                     fifo_write_en;
  logic [WIDTH-1:0]         fifo_data_in;
  logic                     fifo_full;
  logic                     fifo_almost_full;
  logic [IDW-1:0]           grant_id;
  logic                     busy;

  modport master (
    input  req_valid, req_data, fifo_full, fifo_almost_full,
    output req_ready, fifo_write_en, fifo_data_in, grant_id, busy
  );

  modport slave (
    output req_valid, req_data, fifo_full, fifo_almost_full,
    input  req_ready, fifo_write_en, fifo_data_in, grant_id, busy
  );
endinterface

// File: rtl/fifo_write_arbiter.sv
// fifo_write_arbiter
// Round-robin arbiter sharing one FIFO write port between NUM_REQ
// valid/ready producers. One producer holds the grant for a burst of up to
// MAX_BURST beats (1 beat if the FIFO was almost full at grant time).
// FIFO full blocks transfers in the same cycle.
// Ports:
//   clk      : clock, rising edge
//   reset_n  : asynchronous active-low reset
//   bus      : fifo_write_arbiter_if.master (producer handshake, FIFO write
//              port, grant_id, busy)
module fifo_write_arbiter #(
  parameter int NUM_REQ   = 4,
  parameter int WIDTH     = 8,
  parameter int MAX_BURST = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  fifo_write_arbiter_if.master  bus
);
  localparam int IDW  = $clog2(NUM_REQ);
  localparam int CNTW = $clog2(MAX_BURST + 1);

  typedef enum logic {IDLE, GRANT} state_t;

  state_t          state_reg, state_next;
  logic [IDW-1:0]  grant_id_reg, grant_id_next;
  logic [IDW-1:0]  rr_ptr_reg, rr_ptr_next;
  logic [CNTW-1:0] burst_cnt_reg, burst_cnt_next;
  logic [CNTW-1:0] burst_lim_reg, burst_lim_next;

  logic            busy;
  logic            grant_valid;
  logic [IDW-1:0]  ptr_after_grant;
  logic [IDW-1:0]  rr_sel;
  logic [IDW-1:0]  rot_idx [NUM_REQ];
  logic [WIDTH-1:0] data_slice [NUM_REQ];

  // rot_idx[k] is the producer index k positions above rr_ptr, wrapped.
  for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_rot
    logic [IDW:0] sum;
    assign sum         = {1'b0, rr_ptr_reg} + (IDW+1)'(gi);
    assign rot_idx[gi] = (sum >= (IDW+1)'(NUM_REQ)) ? IDW'(sum - (IDW+1)'(NUM_REQ))
                                                     : IDW'(sum);
    assign data_slice[gi]    = bus.req_data[gi*WIDTH +: WIDTH];
    assign bus.req_ready[gi] = busy & (grant_id_reg == IDW'(gi)) & ~bus.fifo_full;
  end

  // Scan from the farthest offset down so the nearest valid offset wins.
  always_comb begin
    rr_sel = rr_ptr_reg;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      if (bus.req_valid[rot_idx[k]]) rr_sel = rot_idx[k];
    end
  end

  assign busy            = (state_reg == GRANT);
  assign grant_valid     = bus.req_valid[grant_id_reg];
  assign ptr_after_grant = (grant_id_reg == IDW'(NUM_REQ - 1)) ? '0
                                                                : grant_id_reg + IDW'(1);

  assign bus.busy          = busy;
  assign bus.grant_id      = grant_id_reg;
  assign bus.fifo_write_en = busy & grant_valid & ~bus.fifo_full;
  assign bus.fifo_data_in  = data_slice[grant_id_reg];

  always_comb begin
    state_next     = state_reg;
    grant_id_next  = grant_id_reg;
    rr_ptr_next    = rr_ptr_reg;
    burst_cnt_next = burst_cnt_reg;
    burst_lim_next = burst_lim_reg;
    case (state_reg)
      IDLE: begin
        if (!bus.fifo_full && (|bus.req_valid)) begin
          grant_id_next  = rr_sel;
          burst_cnt_next = '0;
          burst_lim_next = bus.fifo_almost_full ? CNTW'(1) : CNTW'(MAX_BURST);
          state_next     = GRANT;
        end
      end
      GRANT: begin
        // A dropped valid releases even while the FIFO is full.
        if (!grant_valid) begin
          state_next  = IDLE;
          rr_ptr_next = ptr_after_grant;
        end else if (!bus.fifo_full) begin
          burst_cnt_next = burst_cnt_reg + CNTW'(1);
          if (burst_cnt_reg + CNTW'(1) == burst_lim_reg) begin
            state_next  = IDLE;
            rr_ptr_next = ptr_after_grant;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_reg     <= IDLE;
      grant_id_reg  <= '0;
      rr_ptr_reg    <= '0;
      burst_cnt_reg <= '0;
      burst_lim_reg <= CNTW'(MAX_BURST);
    end else begin
      state_reg     <= state_next;
      grant_id_reg  <= grant_id_next;
      rr_ptr_reg    <= rr_ptr_next;
      burst_cnt_reg <= burst_cnt_next;
      burst_lim_reg <= burst_lim_next;
    end
  end
endmodule

// File: tb/tb_fifo_write_arbiter.sv
// tb_fifo_write_arbiter
// Directed bench for fifo_write_arbiter: queue-driven producers, a
// grant-level reference model and a negedge compare process.
module tb_fifo_write_arbiter;
  localparam int N  = 4;
  localparam int W  = 8;
  localparam int MB = 4;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  fifo_write_arbiter_if #(.NUM_REQ(N), .WIDTH(W)) bus ();
  fifo_write_arbiter #(.NUM_REQ(N), .WIDTH(W), .MAX_BURST(MB)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  int checks = 0;
  int failures = 0;

  logic [W-1:0] q [N][$];    // beats each producer still has to deliver
  logic [N-1:0] hs;          // handshakes seen at the last negedge
  int cyc = 0;
  int stall_left = 0;
  int wlog[$], wcyc[$], glog[$], blog[$], mg[$];

  // Reference model: owner (-1 = none), beats left in the grant, last
  // granted producer and where the next search starts.
  int m_owner = -1, m_credit = 0, m_last = 0, m_start = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int at(input int qq[$], input int idx);
    return (idx < qq.size()) ? qq[idx] : -1;
  endfunction

  task automatic model_reset();
    m_owner = -1; m_credit = 0; m_last = 0; m_start = 0;
  endtask

  task automatic model_step();
    int j;
    if (m_owner < 0) begin
      if (!bus.fifo_full && bus.req_valid != '0) begin
        for (int k = 0; k < N; k++) begin
          j = (m_start + k) % N;
          if (m_owner < 0 && bus.req_valid[j]) m_owner = j;
        end
        m_last   = m_owner;
        m_credit = bus.fifo_almost_full ? 1 : MB;
        mg.push_back(m_owner);
      end
    end else if (!bus.req_valid[m_owner]) begin
      m_start = (m_owner + 1) % N;
      m_owner = -1;
    end else if (!bus.fifo_full) begin
      m_credit--;
      if (m_credit == 0) begin
        m_start = (m_owner + 1) % N;
        m_owner = -1;
      end
    end
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      bus.req_valid[i] = (q[i].size() > 0);
      bus.req_data[i*W +: W] = (q[i].size() > 0) ? q[i][0] : 8'(8'hF0 + i);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    if (reset_n) model_step(); else model_reset();
    #1;
    for (int i = 0; i < N; i++) if (hs[i]) void'(q[i].pop_front());
    bus.fifo_full = 1'b0;
    if (stall_left > 0 && wlog.size() == 2) begin
      bus.fifo_full = 1'b1;
      stall_left--;
    end
    drive();
  endtask

  task automatic clear_logs();
    wlog.delete(); wcyc.delete(); glog.delete(); blog.delete(); mg.delete();
  endtask

  task automatic run_idle(input int maxc);
    int n = 0;
    do begin
      cycle();
      n++;
    end while ((q[0].size() + q[1].size() + q[2].size() + q[3].size() > 0 || m_owner >= 0)
               && n < maxc);
    if (n >= maxc) begin
      checks++; failures++;
      $display("FAIL timeout actual=%0d cycles required=<%0d", n, maxc);
    end
  endtask

  task automatic reset_dut();
    reset_n = 1'b0;
    model_reset();
    for (int i = 0; i < N; i++) q[i].delete();
    drive();
    repeat (2) cycle();
    clear_logs();
    reset_n = 1'b1;
  endtask

  // Compare process: every negedge, DUT outputs against the model.
  initial begin
    logic [N-1:0] prev_v, prev_hs, e_ready;
    logic [N*W-1:0] prev_d;
    logic e_busy, e_we, prev_busy;
    prev_v = '0; prev_hs = '0; prev_d = '0; prev_busy = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      e_busy  = (m_owner >= 0);
      e_we    = e_busy && bus.req_valid[m_owner < 0 ? 0 : m_owner] && !bus.fifo_full;
      e_ready = (e_busy && !bus.fifo_full) ? N'(1 << m_owner) : '0;
      chk("busy", bus.busy, e_busy);
      chk("grant_id", bus.grant_id, m_last);
      chk("fifo_write_en", bus.fifo_write_en, e_we);
      chk("req_ready", bus.req_ready, e_ready);
      chk("fifo_data_in", bus.fifo_data_in, bus.req_data[m_last*W +: W]);
      for (int i = 0; i < N; i++)
        if (reset_n && prev_v[i] && !prev_hs[i])
          chk("producer_hold", {bus.req_valid[i], bus.req_data[i*W +: W]},
              {1'b1, prev_d[i*W +: W]});
      hs = bus.req_valid & bus.req_ready;
      if (bus.busy && !prev_busy) begin
        glog.push_back(int'(bus.grant_id));
        blog.push_back(0);
      end
      if (bus.fifo_write_en) begin
        wlog.push_back(int'(bus.fifo_data_in));
        wcyc.push_back(cyc);
        if (blog.size() > 0) blog[blog.size()-1] = blog[blog.size()-1] + 1;
      end
      prev_busy = bus.busy;
      prev_v = bus.req_valid; prev_hs = hs; prev_d = bus.req_data;
    end
  end

  initial begin
    int c0, n;
    reset_n = 1'b0;
    bus.fifo_full = 1'b0;
    bus.fifo_almost_full = 1'b0;
    hs = '0;
    drive();
    repeat (2) cycle();
    // Reset values
    chk("rst_busy", bus.busy, 1'b0);
    chk("rst_write_en", bus.fifo_write_en, 1'b0);
    chk("rst_ready", bus.req_ready, 4'b0000);
    chk("rst_grant_id", bus.grant_id, 2'd0);
    chk("rst_data_in", bus.fifo_data_in, 8'hF0);
    clear_logs();
    reset_n = 1'b1;

    // Single producer 1, six beats: 4 + 2 with one idle cycle between
    for (int k = 1; k <= 6; k++) q[1].push_back(8'(8'hA0 + k));
    drive();
    c0 = cyc;
    run_idle(40);
    chk("t1_grants", glog.size(), 2);
    chk("t1_grant0", at(glog, 0), 1);
    chk("t1_grant1", at(glog, 1), 1);
    chk("t1_model_grant1", at(mg, 1), 1);
    chk("t1_beats0", at(blog, 0), 4);
    chk("t1_beats1", at(blog, 1), 2);
    for (int k = 0; k < 6; k++) chk("t1_data", at(wlog, k), 8'hA1 + k);
    chk("t1_latency", at(wcyc, 0) - c0, 2);
    chk("t1_back_to_back", at(wcyc, 3) - at(wcyc, 0), 3);
    chk("t1_rearb_gap", at(wcyc, 4) - at(wcyc, 3), 2);

    // All four producers valid: 0,1,2,3,0 each with full bursts
    reset_dut();
    for (int i = 0; i < N; i++)
      for (int k = 0; k < 8; k++) q[i].push_back(8'(i*16 + k));
    drive();
    run_idle(100);
    for (int g = 0; g < 5; g++) begin
      chk("t2_order", at(glog, g), g % N);
      chk("t2_beats", at(blog, g), 4);
    end
    chk("t2_model_wrap", at(mg, 4), 0);
    chk("t2_total", wlog.size(), 32);
    chk("t2_data4", at(wlog, 4), 8'h10);
    chk("t2_data16", at(wlog, 16), 8'h04);

    // FIFO full for three cycles after beat 2 of producer 2
    reset_dut();
    for (int k = 1; k <= 4; k++) q[2].push_back(8'(8'hC0 + k));
    stall_left = 3;
    drive();
    run_idle(40);
    chk("t3_grants", glog.size(), 1);
    chk("t3_grant", at(glog, 0), 2);
    chk("t3_beats", at(blog, 0), 4);
    for (int k = 0; k < 4; k++) chk("t3_data", at(wlog, k), 8'hC1 + k);
    chk("t3_stall_gap", at(wcyc, 2) - at(wcyc, 1), 4);
    chk("t3_resume", at(wcyc, 3) - at(wcyc, 2), 1);

    // Almost full at grant time: one beat per grant, alternating 0,3
    reset_dut();
    bus.fifo_almost_full = 1'b1;
    q[0].push_back(8'hD0); q[0].push_back(8'hD1);
    q[3].push_back(8'hD8); q[3].push_back(8'hD9);
    drive();
    run_idle(40);
    bus.fifo_almost_full = 1'b0;
    chk("t4_g0", at(glog, 0), 0);
    chk("t4_g1", at(glog, 1), 3);
    chk("t4_g2", at(glog, 2), 0);
    chk("t4_model_g1", at(mg, 1), 3);
    for (int g = 0; g < 4; g++) chk("t4_beats", at(blog, g), 1);
    chk("t4_data0", at(wlog, 0), 8'hD0);
    chk("t4_data1", at(wlog, 1), 8'hD8);
    chk("t4_data2", at(wlog, 2), 8'hD1);

    // Producer 1 drops valid after one beat; producer 2 is next
    reset_dut();
    q[1].push_back(8'hB1);
    q[2].push_back(8'hC5); q[2].push_back(8'hC6);
    drive();
    run_idle(40);
    chk("t5_g0", at(glog, 0), 1);
    chk("t5_g1", at(glog, 1), 2);
    chk("t5_beats0", at(blog, 0), 1);
    chk("t5_beats1", at(blog, 1), 2);
    chk("t5_data", at(wlog, 0), 8'hB1);
    chk("t5_release_gap", at(wcyc, 1) - at(wcyc, 0), 3);

    // Reset pulse in the middle of a producer 2 burst
    clear_logs();
    for (int k = 1; k <= 4; k++) q[2].push_back(8'(8'hE0 + k));
    drive();
    n = 0;
    while (wlog.size() < 2 && n < 20) begin
      cycle();
      n++;
    end
    chk("t6_reached_mid", wlog.size(), 2);
    #1;
    reset_n = 1'b0;
    model_reset();
    #1;
    chk("t6_busy", bus.busy, 1'b0);
    chk("t6_write_en", bus.fifo_write_en, 1'b0);
    chk("t6_ready", bus.req_ready, 4'b0000);
    chk("t6_grant_id", bus.grant_id, 2'd0);
    cycle();
    clear_logs();
    reset_n = 1'b1;
    q[3].push_back(8'hB2);
    drive();
    run_idle(40);
    chk("t6_g0", at(glog, 0), 2);
    chk("t6_g1", at(glog, 1), 3);
    chk("t6_beats0", at(blog, 0), 2);
    chk("t6_data0", at(wlog, 0), 8'hE3);
    chk("t6_data1", at(wlog, 1), 8'hE4);
    chk("t6_data2", at(wlog, 2), 8'hB2);
    chk("t6_total", wlog.size(), 3);

    repeat (2) cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/fifo_write_arbiter.md
# fifo_write_arbiter

Round-robin write arbiter that shares one FIFO write port between `NUM_REQ` producers. Each producer offers data through a valid/ready handshake. The arbiter grants one producer at a time for a bounded burst and drives the FIFO `write_en`/`data_in` directly. It reacts to FIFO `full` in the same cycle, so a beat is never presented to a full FIFO and none is lost.

## Interface
- `NUM_REQ`, default 4: number of producers; must be ≥2.
- `WIDTH`, default 8: data width; must equal the FIFO `WIDTH`.
- `MAX_BURST`, default 4: maximum beats per grant; must be ≥1.
- `clk` in 1: single clock; all state updates on its rising edge.
- `reset_n` in 1: asynchronous, active-low reset.
- `req_valid` in `NUM_REQ`: producer i has a beat on its data slice.
- `req_data` in `NUM_REQ*WIDTH`: producer i data at bits `[i*WIDTH +: WIDTH]`.
- `req_ready` out `NUM_REQ`: a beat from producer i is accepted this cycle.
- `fifo_write_en` out 1: connects to FIFO `write_en`.
- `fifo_data_in` out `WIDTH`: connects to FIFO `data_in`.
- `fifo_full` in 1: FIFO `full`.
- `fifo_almost_full` in 1: FIFO `almost_full`.
- `grant_id` out `$clog2(NUM_REQ)`: index of the current or last granted producer.
- `busy` out 1: the arbiter is in state GRANT.

## Operation
- **State machine:** two states, IDLE and GRANT. Registered state:
  - `grant_id`
  - `rr_ptr` (width `$clog2(NUM_REQ)`)
  - `burst_cnt` (width `$clog2(MAX_BURST+1)`)
- **Producer rule:** once `req_valid[i]` is high, producer i holds it and its data stable until `req_ready[i]`. The arbiter does not check this rule; the bench does.
- **IDLE:**
  - Arbitration is skipped while `fifo_full=1`.
  - Otherwise, if any `req_valid` is set, select the first set bit searching upward from `rr_ptr` and wrapping from `NUM_REQ-1` to 0.
  - Register the selection into `grant_id`, clear `burst_cnt`, and go to GRANT.
  - If no request is valid, stay in IDLE.
- **Burst limit:** `burst_lim` is latched at grant time: 1 if `fifo_almost_full=1`, otherwise `MAX_BURST`.
- **GRANT, beat transfer:**
  - A beat transfers when `req_valid[grant_id]=1` and `fifo_full=0`.
  - Each transfer increments `burst_cnt`.
- **GRANT, release:** the grant is released to IDLE at the clock edge when either:
  - the transfer just taken makes `burst_cnt` equal `burst_lim`, or
  - `req_valid[grant_id]=0`. No transfer occurs in that cycle.
- **On release:** `rr_ptr <= grant_id+1`, wrapping `NUM_REQ-1` to 0. `grant_id` keeps its value.
- **FIFO stall:** `fifo_full=1` during GRANT stalls the grant. There is no transfer, `burst_cnt` holds, the grant is kept, and there is no timeout.
- **Combinational outputs** (both are functions of registered state and current inputs only):
  - `fifo_write_en = busy & req_valid[grant_id] & ~fifo_full`.
  - `req_ready[i] = busy & (grant_id==i) & ~fifo_full`.
- **Data mux:** `fifo_data_in` is the `req_data` slice selected by `grant_id`, in every state.
- **Reset (asynchronous, at any time including mid-burst):**
  - state goes to IDLE; `grant_id`, `rr_ptr` and `burst_cnt` go to 0.
  - A beat in flight is neither accepted nor written.

## Timing
- **Reset values:**
  - `fifo_write_en=0`, `req_ready=0`, `busy=0`, `grant_id=0`.
  - `fifo_data_in` equals `req_data[WIDTH-1:0]`, which is combinational.
- **Latency:** one cycle from a valid request seen in IDLE to the first possible transfer.
- **Throughput:**
  - Up to `MAX_BURST` beats on consecutive cycles per grant.
  - One idle (arbitration) cycle between grants, so the peak rate is `MAX_BURST/(MAX_BURST+1)`.
- **Full response:** zero-cycle. `fifo_full` asserted in cycle t forces `fifo_write_en=0` and `req_ready=0` in cycle t.
- **Simultaneous events:**
  - A last-beat transfer and a drop of the requester's valid in the same cycle: the transfer counts, then the grant is released.
  - `fifo_full` and release conditions in the same cycle: only the valid-drop condition applies.
- **Fairness bound:** each continuously-valid producer is granted within `NUM_REQ` arbitration rounds.

## Test plan
- **Reset then single producer:** reset, then `req_valid=4'b0010`, producer 1 sends data 0xA1..0xA6 with `MAX_BURST=4`.
  - Grant 1 after one cycle.
  - Beats 0xA1–0xA4 on consecutive cycles, then one IDLE cycle, then grant 1 again for 0xA5–0xA6.
- **All four producers valid continuously:** grants go in the order 0,1,2,3,0. Each grant writes exactly 4 beats, and `rr_ptr` wraps 3→0.
- **`fifo_full` mid-burst:** assert `fifo_full` for 3 cycles after beat 2 of producer 2.
  - `fifo_write_en=0` in exactly those 3 cycles.
  - `grant_id` stays 2.
  - Beats 3–4 follow, and there is no data loss or duplication.
- **Almost full at grant:** `fifo_almost_full=1` in IDLE with producers 0 and 3 valid. Each grant writes exactly 1 beat, alternating 0,3,0.
- **Valid drop and reset:**
  - Producer 1 drops valid after beat 1: grant released with `burst_cnt=1` and the next grant goes to producer 2.
  - `reset_n` pulsed low mid-burst: `busy=0` and `fifo_write_en=0` immediately, and `grant_id=0` and `rr_ptr=0` after release.
